// File: rtl/tlb_refill_walker.sv
// Sv32 two-level page-table walker that refills the TLB on a miss.
// One PTE read outstanding at a time; every output is a flop decoded from the next state.
module tlb_refill_walker #(
    parameter int unsigned VPN_WIDTH = 20,
    parameter int unsigned PPN_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PPN_WIDTH-1:0] satp_ppn_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_vaddr_i,
    output logic                 resp_valid_o,
    output logic                 resp_fault_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [31:0]          mem_req_addr_o,
    input  logic                 mem_resp_valid_i,
    input  logic [31:0]          mem_resp_data_i,
    output logic                 tlb_wr_en_o,
    output logic [31:0]          tlb_wr_vaddr_o,
    output logic [31:0]          tlb_wr_paddr_o,
    output logic [2:0]           tlb_wr_perm_o
);
    localparam int unsigned VPN_HALF = VPN_WIDTH / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_WRITE, S_FAULT, S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           vaddr_q, vaddr_d;
    logic [31:0]           addr_q, addr_d;
    logic [PPN_WIDTH-1:0]  ppn_d;
    logic [2:0]            perm_d;
    logic                  req_rdy_q, mreq_q, rv_q, rf_q, wr_q;
    logic [31:0]           wva_q, wpa_q;
    logic [2:0]            perm_q;
    logic                  pte_bad, pte_leaf, pte_misaligned;
    logic [VPN_HALF-1:0]   vpn0;
    logic                  unused_pte_bits;

    // PTE classification; A/D/U/G and RSW bits play no part.
    assign pte_bad        = ~mem_resp_data_i[0] | (~mem_resp_data_i[1] & mem_resp_data_i[2])
                          | (|mem_resp_data_i[31:30]);
    assign pte_leaf       = mem_resp_data_i[1] | mem_resp_data_i[3];
    assign pte_misaligned = |mem_resp_data_i[19:10];
    assign vpn0           = vaddr_q[12 +: VPN_HALF];
    assign unused_pte_bits = ^mem_resp_data_i[9:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        vaddr_d = vaddr_q;
        addr_d  = addr_q;
        ppn_d   = '0;
        perm_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    state_d = S_L1_REQ;
                    vaddr_d = req_vaddr_i;
                    addr_d  = {satp_ppn_i, req_vaddr_i[31:22], 2'b00};
                end
            end
            S_L1_REQ, S_L0_REQ: begin
                // A flush racing an accepted request still owes us a response.
                if (flush_i)
                    state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
                else if (mem_req_ready_i)
                    state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
            end
            S_L1_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else if (pte_bad || (pte_leaf && pte_misaligned)) begin
                        state_d = S_FAULT;
                    end else if (pte_leaf) begin
                        state_d = S_WRITE;
                        ppn_d   = {mem_resp_data_i[29:20], vpn0};
                        perm_d  = {mem_resp_data_i[1], mem_resp_data_i[2], mem_resp_data_i[3]};
                    end else begin
                        state_d = S_L0_REQ;
                        addr_d  = {mem_resp_data_i[29:10], vpn0, 2'b00};
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_L0_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else if (pte_bad || !pte_leaf) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_WRITE;
                        ppn_d   = mem_resp_data_i[29:10];
                        perm_d  = {mem_resp_data_i[1], mem_resp_data_i[2], mem_resp_data_i[3]};
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_WRITE, S_FAULT: state_d = S_IDLE;
            S_DRAIN: begin
                if (mem_resp_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath latches and registered outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vaddr_q   <= '0;
            addr_q    <= '0;
            req_rdy_q <= 1'b1;
            mreq_q    <= 1'b0;
            rv_q      <= 1'b0;
            rf_q      <= 1'b0;
            wr_q      <= 1'b0;
            wva_q     <= '0;
            wpa_q     <= '0;
            perm_q    <= '0;
        end else begin
            vaddr_q   <= vaddr_d;
            addr_q    <= addr_d;
            req_rdy_q <= (state_d == S_IDLE);
            mreq_q    <= (state_d == S_L1_REQ) || (state_d == S_L0_REQ);
            rv_q      <= (state_d == S_WRITE) || (state_d == S_FAULT);
            rf_q      <= (state_d == S_FAULT);
            wr_q      <= (state_d == S_WRITE);
            wva_q     <= (state_d == S_WRITE) ? vaddr_q : '0;
            wpa_q     <= (state_d == S_WRITE) ? {ppn_d, 12'h000} : '0;
            perm_q    <= (state_d == S_WRITE) ? perm_d : '0;
        end
    end

    // A flush in IDLE must refuse the request in the same cycle.
    assign req_ready_o     = req_rdy_q & ~flush_i;
    assign mem_req_valid_o = mreq_q;
    assign mem_req_addr_o  = addr_q;
    assign resp_valid_o    = rv_q;
    assign resp_fault_o    = rf_q;
    assign tlb_wr_en_o     = wr_q;
    assign tlb_wr_vaddr_o  = wva_q;
    assign tlb_wr_paddr_o  = wpa_q;
    assign tlb_wr_perm_o   = perm_q;
endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: cycle-exact expectations from a walk-level model,
// directed Sv32 cases, flush/reset corners and randomized walks.
module tb_tlb_refill_walker;
    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] satp_ppn;
    logic        flush, req_valid, req_ready;
    logic [31:0] req_vaddr;
    logic        resp_valid, resp_fault;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        tlb_wr_en;
    logic [31:0] tlb_wr_vaddr, tlb_wr_paddr;
    logic [2:0]  tlb_wr_perm;

    always #5 clk = ~clk;

    tlb_refill_walker dut (
        .clk(clk), .rst(rst), .satp_ppn_i(satp_ppn), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_vaddr_i(req_vaddr),
        .resp_valid_o(resp_valid), .resp_fault_o(resp_fault),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i(mem_resp_data), .tlb_wr_en_o(tlb_wr_en),
        .tlb_wr_vaddr_o(tlb_wr_vaddr), .tlb_wr_paddr_o(tlb_wr_paddr),
        .tlb_wr_perm_o(tlb_wr_perm)
    );

    typedef struct packed {
        logic        fault;
        logic        two;
        logic [31:0] a1;
        logic [31:0] a0;
        logic [31:0] pa;
        logic [2:0]  perm;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;

    logic        exp_rdy = 1'b1, exp_mrv = 1'b0, exp_wr = 1'b0, exp_rv = 1'b0, exp_rf = 1'b0;
    logic [31:0] exp_maddr = '0, exp_wva = '0, exp_wpa = '0;
    logic [2:0]  exp_perm = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every output on every falling edge.
    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("mem_req_valid", 32'(mem_req_valid), 32'(exp_mrv));
        if (exp_mrv) check("mem_req_addr", mem_req_addr, exp_maddr);
        check("tlb_wr_en", 32'(tlb_wr_en), 32'(exp_wr));
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        check("resp_fault", 32'(resp_fault), 32'(exp_rf));
        check("tlb_wr_vaddr", tlb_wr_vaddr, exp_wva);
        check("tlb_wr_paddr", tlb_wr_paddr, exp_wpa);
        check("tlb_wr_perm", 32'(tlb_wr_perm), 32'(exp_perm));
    end

    function automatic logic bad_pte(input logic [31:0] p);
        return (p[0] == 1'b0) || (p[1] == 1'b0 && p[2] == 1'b1) || (p[31:30] != 2'b00);
    endfunction

    // What a whole walk must do, from the Sv32 rules with plain arithmetic.
    function automatic exp_t model(input logic [19:0] satp, input logic [31:0] va,
                                   input logic [31:0] p1, input logic [31:0] p0);
        exp_t e;
        logic [31:0] vpn1, vpn0;
        e = '0;
        vpn1 = 32'(va[31:22]);
        vpn0 = 32'(va[21:12]);
        e.a1 = (32'(satp) << 12) + vpn1 * 32'd4;
        if (bad_pte(p1)) begin
            e.fault = 1'b1;
        end else if (p1[1] || p1[3]) begin
            if (p1[19:10] != 10'd0) e.fault = 1'b1;
            else begin
                e.pa   = (32'(p1[29:20]) << 22) + (vpn0 << 12);
                e.perm = {p1[1], p1[2], p1[3]};
            end
        end else begin
            e.two = 1'b1;
            e.a0  = (32'(p1[29:10]) << 12) + vpn0 * 32'd4;
            if (bad_pte(p0) || !(p0[1] || p0[3])) e.fault = 1'b1;
            else begin
                e.pa   = 32'(p0[29:10]) << 12;
                e.perm = {p0[1], p0[2], p0[3]};
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic f, input logic t, input logic [31:0] a1,
                                input logic [31:0] a0, input logic [31:0] pa, input logic [2:0] pm);
        exp_t e;
        e.fault = f; e.two = t; e.a1 = a1; e.a0 = a0; e.pa = pa; e.perm = pm;
        return e;
    endfunction

    function automatic logic [31:0] mk_pte(input int kind);
        logic [31:0] p;
        logic [2:0]  leaf_xwr [5];
        leaf_xwr = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b100};
        p = $urandom;
        case (kind)
            0: begin p[31:30] = 2'b00; p[3:1] = 3'b000; p[0] = 1'b1; end
            1: begin p[31:30] = 2'b00; p[19:10] = 10'd0; p[3:1] = leaf_xwr[$urandom_range(0, 4)]; p[0] = 1'b1; end
            2: begin
                p[31:30] = 2'b00; p[3:1] = leaf_xwr[$urandom_range(0, 4)]; p[0] = 1'b1;
                if (p[19:10] == 10'd0) p[10] = 1'b1;
            end
            3: p[0] = 1'b0;
            4: begin p[0] = 1'b1; p[2:1] = 2'b10; end
            default: begin p[0] = 1'b1; p[1] = 1'b1; if (p[31:30] == 2'b00) p[30] = 1'b1; end
        endcase
        return p;
    endfunction

    // Advance one cycle and set quiet inputs / idle-or-busy expectations.
    task automatic tick(input bit idle);
        @(posedge clk);
        #1;
        flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        satp_ppn = 20'($urandom); req_vaddr = $urandom;
        req_valid = idle ? 1'b0 : 1'($urandom_range(0, 1));
        exp_rdy = idle; exp_mrv = 1'b0; exp_maddr = '0; exp_wr = 1'b0; exp_rv = 1'b0;
        exp_rf = 1'b0; exp_wva = '0; exp_wpa = '0; exp_perm = '0;
    endtask

    task automatic mem_phase(input logic [31:0] addr, input logic [31:0] data, input int stall, input int lat);
        repeat (stall) begin tick(0); exp_mrv = 1'b1; exp_maddr = addr; end
        tick(0); exp_mrv = 1'b1; exp_maddr = addr; mem_req_ready = 1'b1;
        repeat (lat) tick(0);
        tick(0); mem_resp_valid = 1'b1; mem_resp_data = data;
    endtask

    task automatic walk(input logic [19:0] satp, input logic [31:0] va, input logic [31:0] p1,
                        input logic [31:0] p0, input exp_t e, input int stall, input int lat);
        tick(1); req_valid = 1'b1; satp_ppn = satp; req_vaddr = va;
        mem_phase(e.a1, p1, stall, lat);
        if (e.two) mem_phase(e.a0, p0, stall, lat);
        tick(0);
        flush  = 1'($urandom_range(0, 1));
        exp_rv = 1'b1; exp_rf = e.fault; exp_wr = !e.fault;
        if (!e.fault) begin exp_wva = va; exp_wpa = e.pa; exp_perm = e.perm; end
        tick(1);
    endtask

    // Pin the model to a hand-computed walk, then run the DUT against the literal.
    task automatic directed(input string name, input logic [31:0] p1, input logic [31:0] p0,
                            input exp_t lit, input int stall);
        exp_t m;
        m = model(20'h00080, 32'h12345678, p1, p0);
        check({name, "_model_fault"}, 32'(m.fault), 32'(lit.fault));
        check({name, "_model_two"}, 32'(m.two), 32'(lit.two));
        check({name, "_model_a1"}, m.a1, lit.a1);
        check({name, "_model_a0"}, m.a0, lit.a0);
        check({name, "_model_pa"}, m.pa, lit.pa);
        check({name, "_model_perm"}, 32'(m.perm), 32'(lit.perm));
        walk(20'h00080, 32'h12345678, p1, p0, lit, stall, 0);
    endtask

    initial begin
        exp_t e1, e2, ef1, ef2;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; satp_ppn = '0; req_vaddr = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        e1  = mk(1'b0, 1'b1, 32'h00080120, 32'h00090D14, 32'hABCDE000, 3'b110);
        e2  = mk(1'b0, 1'b0, 32'h00080120, 32'h0, 32'hAAF45000, 3'b101);
        ef1 = mk(1'b1, 1'b0, 32'h00080120, 32'h0, 32'h0, 3'b000);
        ef2 = mk(1'b1, 1'b1, 32'h00080120, 32'h00090D14, 32'h0, 3'b000);
        directed("two_level", 32'h00024001, 32'h2AF37807, e1, 0);
        directed("superpage", 32'h2AB0000B, 32'h0, e2, 0);
        directed("misaligned", 32'h2AB0040B, 32'h0, ef1, 0);
        directed("l1_invalid", 32'h00000000, 32'h0, ef1, 0);
        directed("l0_w_no_r", 32'h00024001, 32'h00000005, ef2, 0);
        directed("l0_wide_ppn", 32'h00024001, 32'hC0000003, ef2, 0);
        directed("stall4", 32'h00024001, 32'h2AF37807, e1, 4);

        // Flush in L1_WAIT, response three cycles later, then a clean walk.
        tick(1); req_valid = 1'b1; satp_ppn = 20'h00080; req_vaddr = 32'h12345678;
        tick(0); exp_mrv = 1'b1; exp_maddr = 32'h00080120; mem_req_ready = 1'b1;
        tick(0); flush = 1'b1;
        tick(0); tick(0);
        tick(0); mem_resp_valid = 1'b1; mem_resp_data = 32'h2AB0000B;
        tick(1);
        walk(20'h00080, 32'h12345678, 32'h00024001, 32'h2AF37807, e1, 0, 0);

        // Flush while the L1 request is still waiting for ready.
        tick(1); req_valid = 1'b1; satp_ppn = 20'h00080; req_vaddr = 32'h12345678;
        tick(0); exp_mrv = 1'b1; exp_maddr = 32'h00080120; flush = 1'b1;
        tick(1);

        // Flush together with the L0 response.
        tick(1); req_valid = 1'b1; satp_ppn = 20'h00080; req_vaddr = 32'h12345678;
        tick(0); exp_mrv = 1'b1; exp_maddr = 32'h00080120; mem_req_ready = 1'b1;
        tick(0); mem_resp_valid = 1'b1; mem_resp_data = 32'h00024001;
        tick(0); exp_mrv = 1'b1; exp_maddr = 32'h00090D14; mem_req_ready = 1'b1;
        tick(0); mem_resp_valid = 1'b1; mem_resp_data = 32'h2AF37807; flush = 1'b1;
        tick(1);

        // Flush in IDLE refuses a request.
        tick(1); req_valid = 1'b1; flush = 1'b1; exp_rdy = 1'b0;
        tick(1);

        // Reset in L0_WAIT, then a stray response.
        tick(1); req_valid = 1'b1; satp_ppn = 20'h00080; req_vaddr = 32'h12345678;
        tick(0); exp_mrv = 1'b1; exp_maddr = 32'h00080120; mem_req_ready = 1'b1;
        tick(0); mem_resp_valid = 1'b1; mem_resp_data = 32'h00024001;
        tick(0); exp_mrv = 1'b1; exp_maddr = 32'h00090D14; mem_req_ready = 1'b1;
        tick(0); req_valid = 1'b0; rst = 1'b1; exp_rdy = 1'b1;
        tick(1); rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h2AF37807;
        tick(1);

        for (int i = 0; i < 120; i++) begin
            logic [19:0] satp;
            logic [31:0] va, p1, p0;
            int k1, k0;
            k1 = $urandom_range(0, 8); if (k1 > 5) k1 = 0;
            k0 = $urandom_range(0, 7); if (k0 > 5) k0 = 1;
            satp = 20'($urandom); va = $urandom;
            p1 = mk_pte(k1); p0 = mk_pte(k0);
            walk(satp, va, p1, p0, model(satp, va, p1, p0),
                 $urandom_range(0, 3), $urandom_range(0, 2));
        end

        tick(1);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tlb_refill_walker.md
Name: tlb_refill_walker

Overview:
- Sv32 hardware page-table walker that is the refill (writer) side of the TLB's write interface.
- On a TLB miss it reads up to two PTEs over a single-outstanding memory read port, then issues one TLB write (wr_en/wr_vaddr/wr_paddr/wr_perm) or reports a page fault.
- Sits between the MEM-stage miss logic, the TLB and the memory read arbiter.
- Physical space is 32 bits: a PTE PPN is usable only when PPN[21:20] == 0.

Parameters:
- VPN_WIDTH, 20, virtual page number width; fixed Sv32 split VPN1 = vaddr[31:22], VPN0 = vaddr[21:12].
- PPN_WIDTH, 20, physical page number width written to the TLB.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- satp_ppn  in  20  root page-table PPN; sampled at request accept
- flush  in  1  abort the current walk (sfence.vma)
- req_valid  in  1  walk request
- req_ready  out  1  high only in IDLE
- req_vaddr  in  32  faulting virtual address
- resp_valid  out  1  one-cycle pulse when a walk ends
- resp_fault  out  1  qualifies resp_valid; 1 = page fault
- mem_req_valid  out  1  PTE read request, held until accepted
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  32  PTE physical address, word-aligned
- mem_resp_valid  in  1  read data valid; at least 1 cycle after acceptance
- mem_resp_data  in  32  PTE
- tlb_wr_en  out  1  one-cycle TLB write pulse
- tlb_wr_vaddr  out  32  latched req_vaddr
- tlb_wr_paddr  out  32  {PPN, 12'h000}
- tlb_wr_perm  out  3  {R, W, X} taken from the leaf PTE

Behaviour:
- Reset: state IDLE; every output 0 except req_ready = 1; internal latches cleared. Reset mid-walk drops the walk with no write and no resp. Any late mem response is ignored because IDLE ignores mem_resp_valid.
- States and transitions:
  - IDLE: accept when req_valid. Latch vaddr and satp_ppn, then go to L1_REQ.
  - L1_REQ: mem_req_addr = {satp_ppn, VPN1, 2'b00}. Go to L1_WAIT on mem_req_ready.
  - L1_WAIT: on mem_resp_valid, check the PTE:
    - fault if V = 0, or (R = 0 && W = 1), or PTE[31:30] != 0;
    - leaf (R|X) with PTE[19:10] != 0: misaligned superpage, fault;
    - aligned leaf: PPN = {PTE[29:20], VPN0}, go to WRITE;
    - otherwise (non-leaf): go to L0_REQ.
  - L0_REQ: mem_req_addr = {PTE[29:10], VPN0, 2'b00}. Go to L0_WAIT on mem_req_ready.
  - L0_WAIT: same V/R/W/PTE[31:30] checks. A non-leaf faults. A leaf gives PPN = PTE[29:10]; go to WRITE.
  - WRITE: one cycle. tlb_wr_en = 1 and resp_valid = 1, resp_fault = 0, then IDLE.
  - FAULT: one cycle. resp_valid = 1, resp_fault = 1, tlb_wr_en = 0, then IDLE.
  - DRAIN: wait for mem_resp_valid, discard the data, go to IDLE with no resp.
- All outputs are registered and decoded from state; no comb path from mem_resp_data to outputs.
- tlb_wr_* and resp_* are stable only in the WRITE/FAULT cycle; they are 0 otherwise.
- A, D, U, G bits are ignored.
- mem_req_valid stays high with a stable address until mem_req_ready. Exactly one request is outstanding.
- Latency, with mem_req_ready = 1 and 1-cycle memory:
  - request accepted at edge N;
  - L1 request cycle N+1; L1 data cycle N+2;
  - L0 request N+3; L0 data N+4;
  - WRITE/resp at N+5 (superpage: N+3).
- Flush:
  - in L1_REQ/L0_REQ with the request not yet accepted: go to IDLE next cycle and drop mem_req_valid.
  - in *_WAIT without mem_resp_valid in the same cycle: go to DRAIN.
  - flush and mem_resp_valid together in *_WAIT: discard the response, go to IDLE.
  - flush in WRITE/FAULT: the pulse still completes.
  - flush in IDLE with req_valid: the request is not accepted (req_ready = 0 while flush).
- Requests arriving while busy are back-pressured (req_ready = 0). No queue.

Test Plan:
- satp_ppn=0x00080, vaddr=0x12345678 -> read 0x00080120 returns 0x00024001 -> read 0x00090D14 returns 0x2AF37807 -> tlb_wr_en pulse with paddr=0xABCDE000, vaddr=0x12345678, perm=3'b110; resp_fault=0; resp at N+5.
- Same vaddr, L1 PTE=0x2AB0000B -> single read, paddr=0xAAF45000, perm=3'b101, resp at N+3.
- L1 PTE=0x2AB0040B (misaligned superpage), L1 PTE=0x00000000 (V=0), L0 PTE=0x00000005 (W without R), L0 PTE=0xC0000003 (PPN beyond 32 bits) -> resp_fault=1, tlb_wr_en never asserted.
- mem_req_ready low 4 cycles -> mem_req_valid/addr held stable; request accepted on cycle 5; results unchanged.
- flush in L1_WAIT, response 3 cycles later -> no tlb_wr_en, no resp; req_ready returns 1 the cycle after the response; the next walk runs cleanly.
- rst asserted in L0_WAIT -> all outputs 0 immediately, req_ready=1; a stray mem_resp_valid afterwards causes no write.
